// File: rtl/run_controller_if.sv
// run_controller_if -- host command port plus sequencer-facing status of the
// run/halt/single-step controller.
//
//   cmd_valid/cmd_op/cmd_arg  host command (valid/ready handshake)
//   cmd_ready                 combinational accept from the controller
//   pc                        program counter from the program sequencer
//   run                       registered fetch enable back to the sequencer
//   halted/bp_hit/bp_armed    status flags
//   step_remaining            clocks left in the current STEP
//   cycle_count               saturating count of run=1 clocks
//
// master = host/sequencer side, slave = run_controller.
interface run_controller_if #(
    parameter int PC_WIDTH   = 8,
    parameter int STEP_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    localparam int ARG_W = (PC_WIDTH > STEP_WIDTH) ? PC_WIDTH : STEP_WIDTH;

    logic                  cmd_valid;
    logic [2:0]            cmd_op;
    logic [ARG_W-1:0]      cmd_arg;
    logic                  cmd_ready;
    logic [PC_WIDTH-1:0]   pc;
    logic                  run;
    logic                  halted;
    logic                  bp_hit;
    logic                  bp_armed;
    logic [STEP_WIDTH-1:0] step_remaining;
    logic [CNT_WIDTH-1:0]  cycle_count;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, pc,
        input  cmd_ready, run, halted, bp_hit, bp_armed, step_remaining, cycle_count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, pc,
        output cmd_ready, run, halted, bp_hit, bp_armed, step_remaining, cycle_count
    );
endinterface

// File: rtl/run_controller.sv
// run_controller -- run/halt/single-step sequencer for the 4-bit CPU.
// Drives the registered fetch enable (run=0 makes the decoder see NOP),
// accepts host commands, halts on a hardware breakpoint on pc and counts
// clocks spent with run=1.
//
// Ports:
//   clk    system clock, all state changes on posedge
//   reset  synchronous, active-low
//   bus    run_controller_if.slave: command handshake, pc in, status out
module run_controller #(
    parameter int PC_WIDTH      = 8,
    parameter int STEP_WIDTH    = 8,
    parameter int CNT_WIDTH     = 16,
    parameter bit START_RUNNING = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    run_controller_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_HALTED   = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_RUN    = 3'b001;
    localparam logic [2:0] OP_HALT   = 3'b010;
    localparam logic [2:0] OP_STEP   = 3'b011;
    localparam logic [2:0] OP_SET_BP = 3'b100;
    localparam logic [2:0] OP_CLR_BP = 3'b101;
    localparam logic [2:0] OP_CLR_CNT = 3'b110;

    localparam logic [STEP_WIDTH-1:0] STEP_ONE = STEP_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
    localparam state_t RESET_STATE = START_RUNNING ? ST_RUNNING : ST_HALTED;

    state_t                state_q, state_d;
    logic                  run_q, run_d;
    logic                  bp_hit_q, bp_hit_d;
    logic                  bp_armed_q, bp_armed_d;
    logic [PC_WIDTH-1:0]   bp_addr_q, bp_addr_d;
    logic [STEP_WIDTH-1:0] step_q, step_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  mask_q, mask_d;

    logic                  cmd_ready;
    logic                  accept;
    logic                  bp_match;
    logic [STEP_WIDTH-1:0] step_arg;

    always_comb begin
        state_d    = state_q;
        bp_hit_d   = bp_hit_q;
        bp_armed_d = bp_armed_q;
        bp_addr_d  = bp_addr_q;
        step_d     = step_q;
        cnt_d      = cnt_q;

        // A step in progress only yields to HALT; everything else waits.
        cmd_ready = (state_q != ST_STEPPING) || (bus.cmd_op == OP_HALT);
        accept    = bus.cmd_valid && cmd_ready;
        step_arg  = bus.cmd_arg[STEP_WIDTH-1:0];

        // mask_q suppresses the compare on the first run cycle after a
        // resume so restarting at the breakpoint address makes progress.
        bp_match = bp_armed_q && run_q && (bus.pc == bp_addr_q) && !mask_q;

        if (state_q == ST_STEPPING && run_q) begin
            step_d = step_q - STEP_ONE;
            if (step_q == STEP_ONE)
                state_d = ST_HALTED;
        end

        if (run_q && (cnt_q != '1))
            cnt_d = cnt_q + CNT_ONE;

        if (accept) begin
            case (bus.cmd_op)
                OP_RUN: begin
                    if (state_q == ST_HALTED) begin
                        state_d  = ST_RUNNING;
                        bp_hit_d = 1'b0;
                    end
                end
                OP_HALT: begin
                    state_d = ST_HALTED;
                    step_d  = '0;
                end
                OP_STEP: begin
                    state_d  = ST_STEPPING;
                    step_d   = (step_arg == '0) ? STEP_ONE : step_arg;
                    bp_hit_d = 1'b0;
                end
                OP_SET_BP: begin
                    bp_addr_d  = bus.cmd_arg[PC_WIDTH-1:0];
                    bp_armed_d = 1'b1;
                end
                OP_CLR_BP:  bp_armed_d = 1'b0;
                OP_CLR_CNT: cnt_d      = '0;
                default: ;  // NOP and reserved op: accepted, no effect
            endcase
        end

        // A breakpoint wins over any state change requested this cycle;
        // a halted controller never holds a pending step count.
        if (bp_match) begin
            state_d  = ST_HALTED;
            step_d   = '0;
            bp_hit_d = 1'b1;
        end

        run_d  = (state_d != ST_HALTED);
        mask_d = (state_q == ST_HALTED) && (state_d != ST_HALTED);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= RESET_STATE;
            run_q      <= START_RUNNING;
            bp_hit_q   <= 1'b0;
            bp_armed_q <= 1'b0;
            bp_addr_q  <= '0;
            step_q     <= '0;
            cnt_q      <= '0;
            mask_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            bp_hit_q   <= bp_hit_d;
            bp_armed_q <= bp_armed_d;
            bp_addr_q  <= bp_addr_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
        end
    end

    assign bus.cmd_ready      = cmd_ready;
    assign bus.run            = run_q;
    assign bus.halted         = (state_q == ST_HALTED);
    assign bus.bp_hit         = bp_hit_q;
    assign bus.bp_armed       = bp_armed_q;
    assign bus.step_remaining = step_q;
    assign bus.cycle_count    = cnt_q;
endmodule

// File: tb/tb_run_controller.sv
// Randomized bench for run_controller with a cycle-level reference model
// that tracks fetch enable, pending step count and flags directly.
module tb_run_controller;
    localparam int PCW = 8;
    localparam int SW  = 8;
    localparam int CW  = 4;
    localparam bit SR  = 1'b1;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int NCYC = 4000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    run_controller_if #(.PC_WIDTH(PCW), .STEP_WIDTH(SW), .CNT_WIDTH(CW)) bus ();

    run_controller #(
        .PC_WIDTH(PCW), .STEP_WIDTH(SW), .CNT_WIDTH(CW), .START_RUNNING(SR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference state: fetch enable, clocks left in a step (0 = not stepping),
    // breakpoint flags, counter, and "first run cycle after a resume".
    bit m_run, m_hit, m_armed, m_fresh;
    int m_steps, m_addr, m_cnt;

    // Current stimulus (held from negedge through the following posedge).
    bit s_rst_n, s_valid;
    int s_op, s_arg, s_pc;

    function automatic bit m_ready(input int op);
        return (m_steps == 0) || (op == 2);
    endfunction

    task automatic model_edge();
        bit acc, match, n_run, n_hit;
        int n_steps;
        if (!s_rst_n) begin
            m_run = SR; m_steps = 0; m_hit = 0; m_armed = 0;
            m_addr = 0; m_cnt = 0; m_fresh = 0;
            return;
        end
        acc   = s_valid && m_ready(s_op);
        match = m_armed && m_run && (s_pc == m_addr) && !m_fresh;
        n_run = m_run; n_steps = m_steps; n_hit = m_hit;

        if (m_steps != 0) begin
            n_steps = m_steps - 1;
            if (n_steps == 0) n_run = 0;
        end
        if (acc) begin
            case (s_op)
                1: if (!m_run) begin n_run = 1; n_hit = 0; end
                2: begin n_run = 0; n_steps = 0; end
                3: begin n_run = 1; n_steps = (s_arg % 256 == 0) ? 1 : s_arg % 256; n_hit = 0; end
                4: begin m_addr = s_arg % 256; m_armed = 1; end
                5: m_armed = 0;
                default: ;
            endcase
        end
        if (match) begin n_run = 0; n_steps = 0; n_hit = 1; end

        if (acc && s_op == 6)        m_cnt = 0;
        else if (m_run && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;

        m_fresh = !m_run && n_run;
        m_run = n_run; m_steps = n_steps; m_hit = n_hit;
    endtask

    task automatic check_outputs();
        chk("run", bus.run, m_run);
        chk("halted", bus.halted, !m_run);
        chk("bp_hit", bus.bp_hit, m_hit);
        chk("bp_armed", bus.bp_armed, m_armed);
        chk("step_remaining", bus.step_remaining, m_steps);
        chk("cycle_count", bus.cycle_count, m_cnt);
    endtask

    initial begin
        reset = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_arg = '0; bus.pc = '0;
        s_rst_n = 0; s_valid = 0; s_op = 0; s_arg = 0; s_pc = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc > 0) check_outputs();

            // Long stretches with few commands let the counter saturate.
            s_rst_n = (cyc >= 2) && ($urandom_range(0, 99) != 0);
            s_valid = ((cyc % 400) < 60) ? ($urandom_range(0, 19) == 0)
                                         : ($urandom_range(0, 9) < 6);
            s_op    = $urandom_range(0, 7);
            s_arg   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255)
                                                  : $urandom_range(0, 7);
            s_pc    = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255)
                                                  : $urandom_range(0, 7);
            reset         = s_rst_n;
            bus.cmd_valid = s_valid;
            bus.cmd_op    = 3'(s_op);
            bus.cmd_arg   = 8'(s_arg);
            bus.pc        = 8'(s_pc);
            #1;
            if (cyc > 0) chk("cmd_ready", bus.cmd_ready, m_ready(s_op));
            @(posedge clk);
            model_edge();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
Run/halt/single-step sequencer for the 4-bit microprocessor. It drives the run input that gates instruction fetch (run=0 forces the NOP 0xCF onto the decoder). It accepts host commands over a valid/ready port, watches pc for a hardware breakpoint, and counts executed cycles. It sits between the debug host and the program sequencer.

Parameters:
PC_WIDTH, 8, width of pc and of the breakpoint address
STEP_WIDTH, 8, width of the step count argument
CNT_WIDTH, 16, width of the executed-cycle counter
START_RUNNING, 1, 1 = enter RUNNING after reset; 0 = enter HALTED

Ports:
clk  in  1  system clock; all state changes on posedge
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  host command present
cmd_op  in  3  000 NOP, 001 RUN, 010 HALT, 011 STEP, 100 SET_BP, 101 CLR_BP, 110 CLR_CNT, 111 reserved
cmd_arg  in  max(PC_WIDTH,STEP_WIDTH)  step count (STEP) or breakpoint address (SET_BP)
cmd_ready  out  1  command accepted this cycle when cmd_valid & cmd_ready
pc  in  PC_WIDTH  current program counter from the sequencer
run  out  1  registered fetch enable to the program sequencer
halted  out  1  state == HALTED
bp_hit  out  1  sticky; set when a breakpoint halted execution
bp_armed  out  1  breakpoint enable register
step_remaining  out  STEP_WIDTH  cycles left in the current STEP
cycle_count  out  CNT_WIDTH  number of cycles with run=1; saturating

Behaviour:
- Reset (reset=0 at posedge) sets the following. The state goes to RUNNING if START_RUNNING else HALTED. run = START_RUNNING. bp_hit=0, bp_armed=0, bp_addr=0, step_remaining=0, cycle_count=0. Reset overrides every other event, including mid-step.
- States: HALTED, RUNNING, STEPPING. run is a registered output: it is 1 in the cycle after entering RUNNING/STEPPING and 0 in the cycle after entering HALTED. Latency from command accept to run change is 1 clock.
- cmd_ready is combinational: 1 in HALTED and RUNNING. In STEPPING it is 1 only when cmd_op==HALT; every other command stalls until the step ends.
- An accepted command's effect depends on the op and the current state:
  - NOP: no effect.
  - RUN: go to RUNNING and clear bp_hit. In RUNNING it is a no-op.
  - HALT: go to HALTED from any state and clear step_remaining.
  - STEP: go to STEPPING, load step_remaining = cmd_arg (0 is treated as 1), and clear bp_hit. In RUNNING it converts to STEPPING with the new count.
  - SET_BP: bp_addr = cmd_arg[PC_WIDTH-1:0] and bp_armed = 1. The state is unchanged.
  - CLR_BP: bp_armed = 0.
  - CLR_CNT: cycle_count = 0; takes priority over that cycle's increment.
  - 111: accepted, no effect.
- STEPPING: while run=1, step_remaining decrements each clock. When it reaches 1 and decrements, the state goes to HALTED, so run is high for exactly N clocks.
- Breakpoint: a match is bp_armed & run & (pc == bp_addr) & ~bp_mask.
  - On a match the state goes to HALTED, bp_hit = 1, and run falls on the next edge.
  - bp_mask is 1 for the first run=1 cycle after leaving HALTED, so resuming at the breakpoint address does not re-halt immediately.
- Simultaneous events all resolve to HALTED with bp_hit set:
  - bp match + accepted HALT.
  - bp match + final step decrement.
- SET_BP while RUNNING takes effect for comparisons from the next cycle.
- cycle_count increments on every clock with run=1 and saturates at all-ones. It does not wrap.

Test Plan:
1. Reset: reset=0 for 2 clocks with START_RUNNING=1, then release. run=1, halted=0, cycle_count increments 1,2,3…; bp_hit=0.
2. Halt and step: from RUNNING, HALT accepted at cycle t, so run=0 at t+1. Then STEP arg=3: run=1 for exactly 3 clocks, step_remaining shows 3→2→1→0, then halted=1. cmd_ready=0 for RUN during the step; STEP arg=0 gives exactly 1 run cycle.
3. Breakpoint: SET_BP 0x05, RUN, with pc sweeping 0x00 upward. At pc=0x05, run=0 on the next clock and bp_hit=1. A following RUN with pc held at 0x05 gives run=1, no re-halt, and bp_hit cleared.
4. Collision: STEP arg=2 with bp_addr equal to pc in the final step cycle. Result is HALTED with bp_hit=1. HALT issued mid-step gives cmd_ready=1, HALTED next clock, step_remaining=0.
5. Counter: preload near max (CNT_WIDTH=4). cycle_count saturates at 0xF while running. CLR_CNT in the same cycle as an increment gives 0.
6. Reset mid-STEP: asserting reset while step_remaining=5 returns all outputs to reset values on the next clock.
